param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/counter_pkg.sv | 11 +
 rtl/bin2gray.sv | 9 +
 rtl/param_updown_counter.sv | 54 +++++
 tb/tb_param_updown_counter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: direction/boundary-mode constants and load clamp shared by the counter
package counter_pkg;
    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic logic [31:0] clamp_load(input logic [31:0] din, input logic [31:0] max_val);
        return din > max_val ? max_val : din;
    endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary-to-Gray encoder
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: loadable up/down counter, wrap or saturate at 0/MAX_VAL; gray port under PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 3,
    parameter int unsigned MAX_VAL = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);
    localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX_VAL);

    logic             at_end;
    logic [WIDTH-1:0] nxt;

    // >= keeps the up path inside 0..MAX_VAL even from an out-of-range start
    assign at_end = (up == CNT_UP) ? (count >= MAX_T) : (count == '0);
    assign tc     = (up == CNT_UP) ? (count == MAX_T) : (count == '0);

    always_comb
        nxt = at_end ? ((sat == MODE_SAT) ? count : ((up == CNT_UP) ? '0 : MAX_T))
                     : ((up == CNT_UP) ? count + 1'b1 : count - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= WIDTH'(clamp_load(32'(din), 32'(MAX_VAL)));
            wrap  <= 1'b0;
        end else if (en) begin
            count <= nxt;
            wrap  <= at_end && (sat == MODE_WRAP);
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
    bin2gray #(.WIDTH(WIDTH)) u_gray (.bin(count), .gray(gray));
`endif
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: scoreboard bench, directed boundary cases then random stimulus vs integer model
module tb_param_updown_counter;
    localparam int W = 4;
    localparam int M = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] count;
    logic         tc, wrap;
`ifdef PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
    logic [W-1:0] gray;
`endif

    param_updown_counter #(.WIDTH(W), .MAX_VAL(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .din(din),
        .count(count), .tc(tc), .wrap(wrap)
`ifdef PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
        , .gray(gray)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int w;
        int t;
    } exp_t;

    exp_t q[$];
    int   m_count = 0;
    int   passed  = 0;
    int   total   = 0;
    bit   done    = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Model: count lives on the ring 0..M; wrap is modular stepping, saturation is a clamp
    task automatic step(input bit r, input bit l, input bit e, input bit u, input bit s, input int d);
        exp_t x;
        int   n;
        @(negedge clk);
        rst = r; load = l; en = e; up = u; sat = s; din = W'(d);
        x.w = 0;
        if (r) m_count = 0;
        else if (l) m_count = (d > M) ? M : d;
        else if (e) begin
            n = m_count + (u ? 1 : -1);
            if (n < 0 || n > M) begin
                if (!s) begin
                    m_count = (n + M + 1) % (M + 1);
                    x.w = 1;
                end
            end else m_count = n;
        end
        x.c = m_count;
        x.t = ((u && m_count == M) || (!u && m_count == 0)) ? 1 : 0;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        int   gtab[10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("count", int'(count), x.c);
                check("wrap", int'(wrap), x.w);
                check("tc", int'(tc), x.t);
`ifdef PARAM_UPDOWN_COUNTER_GRAY_OUT_EN
                check("gray", int'(gray), gtab[x.c]);
`endif
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, 1, 0, 0);
        // up wrap sweep from reset: 1..9,0,1
        for (int i = 0; i < 11; i++) step(0, 0, 1, 1, 0, 0);
        // climb to 6, then reset with load and en also high
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 13);
        step(0, 0, 1, 1, 0, 0);
        // down saturation from loaded 2
        step(0, 1, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0);
        // down wrap from 0 to MAX
        step(0, 0, 1, 0, 0, 0);
        // load clamp with en: no step
        step(0, 1, 1, 1, 0, 13);
        // up saturation at 9
        step(0, 0, 1, 1, 1, 0);
        // direction flip at 9
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 75,
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        @(negedge clk);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", passed, total);
            $fatal(1);
        end
    end
endmodule
